// File: rtl/sc_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// sc_sweep_ctrl
// Sweep sequencer for a stochastic-computing evaluation circuit. For every
// binary input value b in [b_first .. b_last] (wrapping modulo 2^WIDTH) it
// resets the circuit, seeds its state register, closes the state feedback
// loop for STREAM_LEN cycles while holding b steady, counts the ones on the
// stochastic output and reports (b, count) over a valid/ready handshake.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, abort             : sweep start pulse (IDLE only), abort level
//   b_first, b_last          : sweep range, latched on start
//   busy, done               : status; done pulses once at sweep end
//   cir_rst_n                : active-low reset to the circuit (low in SEED)
//   cir_input_s, cir_input_b : circuit state and binary inputs
//   cir_output_s             : circuit next state (fed back during RUN)
//   cir_output_circuit       : circuit stochastic output bit (counted)
//   res_valid, res_ready     : result handshake
//   res_b, res_count         : reported input value and ones count
// All outputs are registered.
// -----------------------------------------------------------------------------
module sc_sweep_ctrl #(
    parameter int WIDTH      = 8,
    parameter int STREAM_LEN = 255,
    parameter int SEED       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] b_first,
    input  logic [WIDTH-1:0] b_last,
    output logic             busy,
    output logic             done,
    output logic             cir_rst_n,
    output logic [WIDTH-1:0] cir_input_s,
    output logic [WIDTH-1:0] cir_input_b,
    input  logic [WIDTH-1:0] cir_output_s,
    input  logic             cir_output_circuit,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_b,
    output logic [WIDTH-1:0] res_count
);

    localparam logic [WIDTH-1:0] SEED_V   = WIDTH'(SEED);
    localparam logic [WIDTH-1:0] LAST_CYC = WIDTH'(STREAM_LEN - 1);
    localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V    = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEED   = 3'd1,
        ST_RUN    = 3'd2,
        ST_REPORT = 3'd3,
        ST_NEXT   = 3'd4,
        ST_FIN    = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    logic [WIDTH-1:0] b_r;          // current point, drives cir_input_b
    logic [WIDTH-1:0] b_last_r;
    logic [WIDTH-1:0] cyc_r;        // RUN cycle index
    logic [WIDTH-1:0] count_r;      // ones counted so far in this point
    logic [WIDTH-1:0] count_inc_s;  // count including the current sample

    logic             busy_d_s;
    logic             done_d_s;
    logic             res_valid_d_s;
    logic             cir_rst_n_d_s;

    assign cir_input_b = b_r;
    assign count_inc_s = count_r + (cir_output_circuit ? ONE_V : ZERO_V);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort from any active state overrides everything,
    // including a handshake completing in the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SEED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEED: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (cyc_r == LAST_CYC) begin
                    state_nxt_s = ST_REPORT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_REPORT: begin
                // res_valid is registered high for the whole REPORT dwell
                if (res_ready) begin
                    state_nxt_s = ST_NEXT;
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            ST_NEXT: begin
                if (b_r == b_last_r) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_SEED;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (abort && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe.
    always_comb begin
        busy_d_s      = 1'b0;
        done_d_s      = 1'b0;
        res_valid_d_s = 1'b0;
        cir_rst_n_d_s = 1'b1;
        case (state_nxt_s)
            ST_IDLE: begin
                busy_d_s = 1'b0;
            end
            ST_SEED: begin
                busy_d_s      = 1'b1;
                cir_rst_n_d_s = 1'b0;
            end
            ST_RUN: begin
                busy_d_s = 1'b1;
            end
            ST_REPORT: begin
                busy_d_s      = 1'b1;
                res_valid_d_s = 1'b1;
            end
            ST_NEXT: begin
                busy_d_s = 1'b1;
            end
            ST_FIN: begin
                busy_d_s = 1'b1;
                done_d_s = 1'b1;
            end
            default: begin
                busy_d_s = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            res_valid <= 1'b0;
            cir_rst_n <= 1'b0;
        end else begin
            busy      <= busy_d_s;
            done      <= done_d_s;
            res_valid <= res_valid_d_s;
            cir_rst_n <= cir_rst_n_d_s;
        end
    end

    // Datapath: point value, range end, cycle counter, ones counter,
    // circuit state feedback and the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_r         <= ZERO_V;
            b_last_r    <= ZERO_V;
            cyc_r       <= ZERO_V;
            count_r     <= ZERO_V;
            cir_input_s <= SEED_V;
            res_b       <= ZERO_V;
            res_count   <= ZERO_V;
        end else begin
            if ((state_r == ST_IDLE) && (state_nxt_s == ST_SEED)) begin
                b_r      <= b_first;
                b_last_r <= b_last;
            end else if ((state_r == ST_NEXT) && (state_nxt_s == ST_SEED)) begin
                b_r <= b_r + ONE_V;
            end else begin
                b_r <= b_r;
            end

            if (state_nxt_s == ST_SEED) begin
                cyc_r       <= ZERO_V;
                count_r     <= ZERO_V;
                cir_input_s <= SEED_V;
            end else if ((state_r == ST_RUN) && (state_nxt_s != ST_IDLE)) begin
                cyc_r       <= cyc_r + ONE_V;
                count_r     <= count_inc_s;
                cir_input_s <= cir_output_s;
            end else begin
                // frozen outside RUN, in particular while REPORT waits
                cyc_r       <= cyc_r;
                count_r     <= count_r;
                cir_input_s <= cir_input_s;
            end

            // Capture the result on the last RUN edge, including its sample.
            if ((state_r == ST_RUN) && (state_nxt_s == ST_REPORT)) begin
                res_b     <= b_r;
                res_count <= count_inc_s;
            end else begin
                res_b     <= res_b;
                res_count <= res_count;
            end
        end
    end

endmodule

// File: tb/tb_sc_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sc_sweep_ctrl
// Drives sc_sweep_ctrl against a behavioural evaluation circuit
// (output_circuit = input_s < input_b, output_s = maximal-length 8-bit LFSR)
// and checks every reported point against a reference computed by iterating
// the LFSR from the seed for one stream length.
// -----------------------------------------------------------------------------
module tb_sc_sweep_ctrl;

    localparam int L     = 255;
    localparam int SEEDV = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] b_first;
    logic [7:0] b_last;
    logic       busy;
    logic       done;
    logic       cir_rst_n;
    logic [7:0] cir_input_s;
    logic [7:0] cir_input_b;
    logic [7:0] cir_output_s;
    logic       cir_output_circuit;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_b;
    logic [7:0] res_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sc_sweep_ctrl #(.WIDTH(8), .STREAM_LEN(L), .SEED(SEEDV)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .b_first            (b_first),
        .b_last             (b_last),
        .busy               (busy),
        .done               (done),
        .cir_rst_n          (cir_rst_n),
        .cir_input_s        (cir_input_s),
        .cir_input_b        (cir_input_b),
        .cir_output_s       (cir_output_s),
        .cir_output_circuit (cir_output_circuit),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_b              (res_b),
        .res_count          (res_count)
    );

    // Galois LFSR, polynomial x^8+x^6+x^5+x^4+1 (period 255 over nonzero states)
    function automatic logic [7:0] lfsr(input logic [7:0] s);
        logic [7:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 8'hB8;
        return n;
    endfunction

    // Evaluation circuit model
    assign cir_output_s       = lfsr(cir_input_s);
    assign cir_output_circuit = (cir_input_s < cir_input_b);

    // Reference: ones seen over L stream samples starting from the seed
    function automatic int exp_count(input logic [7:0] b);
        logic [7:0] s;
        int c;
        s = 8'(SEEDV);
        c = 0;
        for (int i = 0; i < L; i++) begin
            if (s < b) c++;
            s = lfsr(s);
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: random ready, 2: stall first result 10 cycles
    task automatic run_sweep(input logic [7:0] bf, input logic [7:0] bl,
                             input int mode, output int done_cyc);
        logic [7:0] diff;
        logic [7:0] b_exp;
        logic [7:0] held_s;
        int npts, got, cycles, budget;
        bit seen_done, stalled;
        diff      = bl - bf;
        npts      = int'(diff) + 1;
        b_exp     = bf;
        got       = 0;
        seen_done = 1'b0;
        stalled   = 1'b0;
        done_cyc  = -1;
        budget    = npts * (L + 40) + 40;
        b_first   = bf;
        b_last    = bl;
        res_ready = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        chk("seed_busy",  32'(busy), 32'd1);
        chk("seed_rst_n", 32'(cir_rst_n), 32'd0);
        chk("seed_state", 32'(cir_input_s), 32'(SEEDV));
        chk("seed_b",     32'(cir_input_b), 32'(bf));
        while (!seen_done && cycles < budget) begin
            if (mode == 2 && !stalled && res_valid) begin
                stalled   = 1'b1;
                held_s    = cir_input_s;
                res_ready = 1'b0;
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #1;
                    cycles++;
                    chk("bp_valid", 32'(res_valid), 32'd1);
                    chk("bp_b",     32'(res_b), 32'(b_exp));
                    chk("bp_count", 32'(res_count), 32'(exp_count(b_exp)));
                    chk("bp_state", 32'(cir_input_s), 32'(held_s));
                end
            end
            res_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (res_valid && res_ready) begin
                chk("res_b",     32'(res_b), 32'(b_exp));
                chk("res_count", 32'(res_count), 32'(exp_count(b_exp)));
                got++;
                b_exp = b_exp + 8'd1;
            end
            @(posedge clk); #1;
            cycles++;
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cycles;
            end
        end
        res_ready = 1'b0;
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("n_results", 32'(got), 32'(npts));
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);
        chk("idle_busy",  32'(busy), 32'd0);
    endtask

    initial begin
        int dc;
        int viol;
        int wait_cnt;
        logic [7:0] rb;
        logic [7:0] full_b;
        int full_got;
        int full_done;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        b_first = 8'd0; b_last = 8'd0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_valid",  32'(res_valid), 32'd0);
        chk("rst_res_b",  32'(res_b), 32'd0);
        chk("rst_count",  32'(res_count), 32'd0);
        chk("rst_rst_n",  32'(cir_rst_n), 32'd0);
        chk("rst_in_s",   32'(cir_input_s), 32'(SEEDV));
        chk("rst_in_b",   32'(cir_input_b), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_rst_n", 32'(cir_rst_n), 32'd1);

        // Single point b=100
        run_sweep(8'd100, 8'd100, 0, dc);
        chk("single_done_cycle", 32'(dc), 32'(L + 4));
        chk("single_count_closed", 32'(exp_count(8'd100)), 32'd99);

        // Wrap 254 -> 1
        run_sweep(8'd254, 8'd1, 0, dc);

        // Backpressure on first result
        run_sweep(8'd10, 8'd11, 2, dc);

        // Abort mid-RUN at b=5
        b_first = 8'd3; b_last = 8'd9; res_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cnt = 0;
        while (!(cir_input_b == 8'd5 && cir_rst_n && busy && !res_valid) && wait_cnt < 3 * (L + 10)) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("abort_reach_b5", 32'(cir_input_b), 32'd5);
        repeat (20) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_valid", 32'(res_valid), 32'd0);
        chk("abort_done",  32'(done), 32'd0);
        viol = 0;
        for (int i = 0; i < L + 20; i++) begin
            @(posedge clk); #1;
            if (done || res_valid || busy) viol++;
        end
        chk("abort_quiet", 32'(viol), 32'd0);
        run_sweep(8'd3, 8'd4, 0, dc);

        // Reset during REPORT with ready high
        b_first = 8'd20; b_last = 8'd21; res_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_cnt = 0;
        while (!res_valid && wait_cnt < L + 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("rr_valid_before", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("rr_busy",  32'(busy), 32'd0);
        chk("rr_valid", 32'(res_valid), 32'd0);
        chk("rr_res_b", 32'(res_b), 32'd0);
        chk("rr_count", 32'(res_count), 32'd0);
        chk("rr_rst_n", 32'(cir_rst_n), 32'd0);
        chk("rr_in_s",  32'(cir_input_s), 32'(SEEDV));
        chk("rr_in_b",  32'(cir_input_b), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rr_idle_rst_n", 32'(cir_rst_n), 32'd1);
        chk("rr_idle_busy",  32'(busy), 32'd0);
        run_sweep(8'd20, 8'd21, 0, dc);

        // Randomized short sweeps with random backpressure
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom_range(0, 255));
            run_sweep(rb, rb + 8'($urandom_range(0, 2)), 1, dc);
        end

        // Full sweep 0 -> 255, closed-form count check
        b_first = 8'd0; b_last = 8'd255; res_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        full_b = 8'd0; full_got = 0; full_done = 0;
        for (int c = 0; c < 256 * (L + 3) + 20 && full_done == 0; c++) begin
            if (res_valid) begin
                chk("full_b", 32'(res_b), 32'(full_b));
                chk("full_count", 32'(res_count), (full_b == 8'd0) ? 32'd0 : 32'(full_b) - 32'd1);
                full_got++;
                full_b = full_b + 8'd1;
            end
            @(posedge clk); #1;
            if (done) full_done++;
        end
        chk("full_results", 32'(full_got), 32'd256);
        chk("full_done_seen", 32'(full_done), 32'd1);
        viol = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) viol++;
        end
        chk("full_single_done", 32'(viol), 32'd0);
        res_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_sweep_ctrl.md
# sc_sweep_ctrl

Sequencer for the stochastic-computing evaluation circuit. It replaces the free-running bench stimulus with a controlled sweep. For each binary input value it seeds and closes the random-number-state feedback loop (`input_s` ← `output_s`) and holds `input_b` steady for exactly one stream length. It counts the ones on `output_circuit` and reports one (b, count) result per point over a valid/ready handshake. It sits between a host/bench and one `circuit` instance and is the only driver of that instance's inputs.

## Interface
Parameters:
- `WIDTH`, 8: width of `input_s`, `input_b`, `output_s` and the result count.
- `STREAM_LEN`, 255: cycles per evaluation point. Legal range is 1 to 2^WIDTH−1.
- `SEED`, 1: state loaded into `input_s` at the start of every point. Must be nonzero.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: one-cycle pulse. Sampled only in IDLE.
- `abort`, in, 1: level. Terminates the sweep.
- `b_first`, in, WIDTH: first input value. Latched on start.
- `b_last`, in, WIDTH: last input value. Latched on start.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the last point's result is accepted.
- `cir_rst_n`, out, 1: active-low reset to the circuit instance.
- `cir_input_s`, out, WIDTH: state input to the circuit.
- `cir_input_b`, out, WIDTH: binary input to the circuit.
- `cir_output_s`, in, WIDTH: next state from the circuit.
- `cir_output_circuit`, in, 1: stochastic output bit from the circuit.
- `res_valid`, out, 1: result available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_b`, out, WIDTH: input value of the reported point.
- `res_count`, out, WIDTH: number of ones counted for that point.

## Operation
- FSM states: IDLE, SEED, RUN, REPORT, NEXT, FIN.
- **IDLE**: `start`=1 latches `b_first`/`b_last` and sets the b register to `b_first`, then goes to SEED. `start` in any other state is ignored.
- **SEED** (1 cycle):
  - `cir_input_s` ← SEED.
  - Count ← 0.
  - Cycle counter ← 0.
  - `cir_rst_n`=0 for this cycle only. The circuit starts each point from its reset state.
- **RUN** (STREAM_LEN cycles):
  - Each cycle, `cir_input_s` ← `cir_output_s` (registered feedback).
  - Each cycle, count += `cir_output_circuit`.
  - `cir_input_b` holds b.
  - After cycle STREAM_LEN−1, go to REPORT.
- **REPORT**:
  - `res_valid`=1.
  - `res_b`/`res_count` are stable while waiting.
  - When `res_valid`&`res_ready`, go to NEXT. The circuit state is frozen in this state: `cir_input_s` holds its value.
- **NEXT** (1 cycle): if b == b_last, go to FIN. Otherwise b ← b+1 (mod 2^WIDTH) and go to SEED.
- **FIN** (1 cycle): `done`=1, then go to IDLE.
- **Wrap**: if `b_last` < `b_first`, the sweep passes through 2^WIDTH−1 and continues at 0 up to `b_last`. If `b_first` == `b_last`, exactly one point is run.
- **Count width**: the count cannot overflow because STREAM_LEN ≤ 2^WIDTH−1.
- **Abort**: `abort`=1 in any non-IDLE state goes to IDLE on the next edge.
  - `done` does not pulse.
  - `res_valid` drops.
  - A result pending in REPORT is discarded.
  - Abort takes priority over `res_ready` in the same cycle.

## Timing
- **Reset values**:
  - `busy`=0, `done`=0, `res_valid`=0.
  - `res_b`=0, `res_count`=0.
  - `cir_rst_n`=0 during reset, 1 in IDLE afterwards.
  - `cir_input_s`=SEED, `cir_input_b`=0.
- **Mid-operation reset**: reset at any state gives the values above on the next edge. It behaves identically to abort, plus `res_b`/`res_count` are cleared.
- **`start` to first RUN cycle**: 2 edges (IDLE→SEED→RUN).
- **Cycles per point**: 1 (SEED) + STREAM_LEN (RUN) + REPORT dwell (≥1) + 1 (NEXT).
- **Single point with `res_ready` held high**: `start` edge to `done` pulse is STREAM_LEN+4 cycles.
- **Outputs**: all registered. `busy` rises on the edge that leaves IDLE.
- **`res_count` contents**: exactly STREAM_LEN samples, taken on the RUN cycles whose `cir_input_s` values are SEED, f(SEED), … .

## Test plan
Circuit model used below: `output_circuit` = (`input_s` < `input_b`); `output_s` = maximal-length 8-bit LFSR of `input_s`.

- **Single point**: `b_first`=`b_last`=100, `res_ready`=1 → one result with `res_b`=100, `res_count`=99. `done` pulses at cycle STREAM_LEN+4 after `start`.
- **Full sweep**: 0→255 with `res_ready`=1 → 256 results, in order, with `res_count`=max(b−1,0). Exactly one `done`.
- **Wrap**: `b_first`=254, `b_last`=1 → `res_b` sequence 254, 255, 0, 1. Then `done`.
- **Backpressure**: hold `res_ready`=0 for 10 cycles in REPORT → `res_valid` and `res_b`/`res_count` stay stable. `cir_input_s` is unchanged. The sweep resumes after the handshake.
- **Abort mid-RUN at b=5**: → IDLE on the next edge, `busy`=0, no `done`, no further results. A new `start` runs cleanly from `b_first`.
- **`rst` asserted during REPORT with `res_ready`=1**: → no handshake completes. All outputs take their reset values, and the counts of the next sweep are correct.
